// File: rtl/bsg_link_piso_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bsg_link_piso_pkg
// Purpose : Shared definitions for the link PISO stage. Provides the
//           beats-per-word and counter-width derivations and the beat-order
//           enumeration used to pick the output slice / shift direction.
// Revision: 1.0 - initial release
// ============================================================================
package bsg_link_piso_pkg;

    typedef enum logic {
        e_lsb_first = 1'b0,
        e_msb_first = 1'b1
    } beat_order_e;

    // Number of narrow beats carried by one wide word.
    function automatic int els_f(input int width, input int channel_width);
        return width / channel_width;
    endfunction

    // Beat counter width; never below one bit so the counter stays legal.
    function automatic int cnt_width_f(input int els);
        return (els < 2) ? 1 : $clog2(els);
    endfunction

    function automatic beat_order_e beat_order_f(input bit lsb_first);
        return lsb_first ? e_lsb_first : e_msb_first;
    endfunction

endpackage : bsg_link_piso_pkg
`default_nettype wire

// File: rtl/bsg_link_piso_beat_counter.sv
`default_nettype none
// ============================================================================
// Module  : bsg_link_piso_beat_counter
// Purpose : Counts beats already sent for the word held in the PISO stage.
//           Clear has priority over increment; the count only returns to
//           zero through a clear (word load or final beat accepted).
// Ports   : clk       - clock, rising edge
//           rst_n     - asynchronous active-low reset
//           i_clear   - force count to zero
//           i_inc     - advance count by one
//           o_at_last - count equals ELS-1 (final beat of the word)
// Revision: 1.0 - initial release
// ============================================================================
module bsg_link_piso_beat_counter
    import bsg_link_piso_pkg::*;
#(
    parameter int ELS       = 4,
    parameter int CNT_WIDTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_at_last
);

    localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(ELS - 1);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_last = (r_cnt == c_LAST);

endmodule : bsg_link_piso_beat_counter
`default_nettype wire

// File: rtl/bsg_link_piso_stage.sv
`default_nettype none
// ============================================================================
// Module  : bsg_link_piso_stage
// Purpose : Parallel-in serial-out stage between the two-element FIFO and
//           the link PHY. Dequeues one wide word at a time and emits it as
//           WIDTH_P/CHANNEL_WIDTH_P narrow beats on a ready/valid channel,
//           flagging the final beat. A new word is loaded in the same cycle
//           the final beat is accepted, so beats stream with no bubbles.
// Ports   : clk_i       - clock, rising edge
//           reset_i     - asynchronous active-low reset
//           v_i/data_i  - wide word from the FIFO (valid, data)
//           yumi_o      - dequeue strobe to the FIFO
//           v_o/data_o  - narrow beat valid / data
//           last_o      - current beat is the last of its word
//           ready_and_i - downstream accepts the beat
// Revision: 1.0 - initial release
// ============================================================================
module bsg_link_piso_stage
    import bsg_link_piso_pkg::*;
#(
    parameter int WIDTH_P         = 16,
    parameter int CHANNEL_WIDTH_P = 4,
    parameter bit LSB_FIRST_P     = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [WIDTH_P-1:0]         data_i,
    output logic                       yumi_o,
    output logic                       v_o,
    output logic [CHANNEL_WIDTH_P-1:0] data_o,
    output logic                       last_o,
    input  logic                       ready_and_i
);

    // WIDTH_P must be a multiple of CHANNEL_WIDTH_P with at least two beats.
    localparam int          c_ELS       = els_f(WIDTH_P, CHANNEL_WIDTH_P);
    localparam int          c_CNT_WIDTH = cnt_width_f(c_ELS);
    localparam beat_order_e c_ORDER     = beat_order_f(LSB_FIRST_P);

    logic                 r_full;
    logic [WIDTH_P-1:0]   r_shreg;
    logic [WIDTH_P-1:0]   w_shifted;
    logic                 w_at_last;
    logic                 w_send;
    logic                 w_done;
    logic                 w_yumi;

    // Outputs depend on registers only (yumi_o excepted).
    assign v_o    = r_full;
    assign last_o = r_full & w_at_last;

    assign w_send = r_full & ready_and_i;
    assign w_done = w_send & w_at_last;
    // Gated by reset so the FIFO is never dequeued while the stage is held.
    assign w_yumi = reset_i & v_i & (~r_full | w_done);
    assign yumi_o = w_yumi;

    // The output slice sits at the end the shift moves toward; zero fill.
    generate
        if (c_ORDER == e_lsb_first) begin : g_lsb_first
            assign data_o    = r_shreg[CHANNEL_WIDTH_P-1:0];
            assign w_shifted = r_shreg >> CHANNEL_WIDTH_P;
        end else begin : g_msb_first
            assign data_o    = r_shreg[WIDTH_P-1 -: CHANNEL_WIDTH_P];
            assign w_shifted = r_shreg << CHANNEL_WIDTH_P;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_full  <= 1'b0;
            r_shreg <= '0;
        end else if (w_yumi) begin
            r_full  <= 1'b1;
            r_shreg <= data_i;
        end else if (w_done) begin
            r_full  <= 1'b0;
        end else if (w_send) begin
            r_shreg <= w_shifted;
        end
    end

    bsg_link_piso_beat_counter #(
        .ELS       (c_ELS),
        .CNT_WIDTH (c_CNT_WIDTH)
    ) u_beat_counter (
        .clk       (clk_i),
        .rst_n     (reset_i),
        .i_clear   (w_yumi | w_done),
        .i_inc     (w_send),
        .o_at_last (w_at_last)
    );

endmodule : bsg_link_piso_stage
`default_nettype wire

// File: tb/tb_bsg_link_piso_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_bsg_link_piso_stage
// Purpose : Self-checking bench for bsg_link_piso_stage. Two instances (LSB
//           first and MSB first) share one bench-owned FIFO and one ready
//           line. A queue-of-pending-beats model predicts every output.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bsg_link_piso_stage;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [15:0] data_i;
    logic        ready_and_i;

    logic        yumi_l, v_l, last_l;
    logic [3:0]  data_l;
    logic        yumi_m, v_m, last_m;
    logic [3:0]  data_m;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] fifo[$];
    logic [3:0]  ql[$];      // beats still to be sent, LSB-first instance
    logic [3:0]  qm[$];      // beats still to be sent, MSB-first instance
    logic [3:0]  got_l[$];
    logic [3:0]  got_m[$];

    always #5 clk_i = ~clk_i;

    bsg_link_piso_stage #(.WIDTH_P(16), .CHANNEL_WIDTH_P(4), .LSB_FIRST_P(1'b1)) dut_l (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .yumi_o(yumi_l), .v_o(v_l), .data_o(data_l), .last_o(last_l),
        .ready_and_i(ready_and_i));

    bsg_link_piso_stage #(.WIDTH_P(16), .CHANNEL_WIDTH_P(4), .LSB_FIRST_P(1'b0)) dut_m (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .yumi_o(yumi_m), .v_o(v_m), .data_o(data_m), .last_o(last_m),
        .ready_and_i(ready_and_i));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // exp packs n nibbles, first beat in the most significant position.
    task automatic check_beats(input string tag, input logic [3:0] got[$],
                               input logic [31:0] exp, input int n);
        logic [31:0] e;
        check({tag, "_count"}, 32'(got.size() >= n), 32'd1);
        if (got.size() >= n) begin
            e = exp;
            for (int i = 0; i < n; i++)
                check(tag, 32'(got[i]), 32'(e[4*(n-1-i) +: 4]));
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle against the
    // model, advance the model on the rising edge. Starts/ends at posedge+1.
    task automatic step(input bit rdy);
        bit ey;
        logic [15:0] w;
        ready_and_i = rdy;
        v_i    = (fifo.size() > 0);
        data_i = v_i ? fifo[0] : 16'h0;
        #2;
        ey = reset_i && v_i && (ql.size() == 0 || (rdy && ql.size() == 1));
        check("yumi_l", 32'(yumi_l), 32'(ey));
        check("yumi_m", 32'(yumi_m), 32'(ey));
        check("v_l", 32'(v_l), 32'(ql.size() > 0));
        check("v_m", 32'(v_m), 32'(qm.size() > 0));
        check("last_l", 32'(last_l), 32'(ql.size() == 1));
        check("last_m", 32'(last_m), 32'(qm.size() == 1));
        if (ql.size() > 0) check("data_l", 32'(data_l), 32'(ql[0]));
        if (qm.size() > 0) check("data_m", 32'(data_m), 32'(qm[0]));
        if (!reset_i) begin
            check("data_l_rst", 32'(data_l), 32'h0);
            check("data_m_rst", 32'(data_m), 32'h0);
        end
        @(posedge clk_i);
        if (reset_i) begin
            if (rdy && ql.size() > 0) begin
                got_l.push_back(ql.pop_front());
                got_m.push_back(qm.pop_front());
            end
            if (ey) begin
                w = fifo.pop_front();
                for (int i = 0; i < 4; i++) begin
                    ql.push_back(w[4*i +: 4]);
                    qm.push_back(w[4*(3-i) +: 4]);
                end
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && (ql.size() > 0 || fifo.size() > 0); k++)
            step(1'b1);
        got_l.delete();
        got_m.delete();
    endtask

    initial begin
        reset_i     = 1'b0;
        v_i         = 1'b0;
        data_i      = 16'h0;
        ready_and_i = 1'b0;
        #1;
        check("rst_v_l", 32'(v_l), 32'h0);
        check("rst_v_m", 32'(v_m), 32'h0);
        check("rst_yumi_l", 32'(yumi_l), 32'h0);
        check("rst_last_l", 32'(last_l), 32'h0);
        check("rst_data_l", 32'(data_l), 32'h0);
        @(posedge clk_i); @(posedge clk_i); #1;
        reset_i = 1'b1;

        // Single word, ready held high
        fifo.push_back(16'hABCD);
        for (int k = 0; k < 6; k++) step(1'b1);
        check_beats("single_l", got_l, 32'hDCBA, 4);
        check_beats("single_m", got_m, 32'hABCD, 4);
        drain();

        // Back-to-back words
        fifo.push_back(16'h1234);
        fifo.push_back(16'h5678);
        for (int k = 0; k < 10; k++) step(1'b1);
        check_beats("b2b_l", got_l, 32'h43218765, 8);
        check_beats("b2b_m", got_m, 32'h12345678, 8);
        drain();

        // Stall after two beats with another word waiting
        fifo.push_back(16'hABCD);
        step(1'b1);                       // load
        fifo.push_back(16'h1111);
        step(1'b1);                       // beat D
        step(1'b1);                       // beat C
        for (int k = 0; k < 5; k++) begin
            step(1'b0);
            check("stall_data_l", 32'(data_l), 32'hB);
            check("stall_v_l", 32'(v_l), 32'h1);
        end
        for (int k = 0; k < 3; k++) step(1'b1);
        check_beats("stall_l", got_l, 32'hDCBA, 4);
        drain();

        // Reset in the middle of a word
        fifo.push_back(16'hABCD);
        step(1'b1); step(1'b1); step(1'b1);
        fifo.push_back(16'h0F0F);
        reset_i = 1'b0;
        #1;
        check("midrst_v_l", 32'(v_l), 32'h0);
        check("midrst_v_m", 32'(v_m), 32'h0);
        check("midrst_last_l", 32'(last_l), 32'h0);
        ql.delete();
        qm.delete();
        @(posedge clk_i); #1;
        step(1'b1);
        step(1'b1);
        reset_i = 1'b1;
        got_l.delete();
        got_m.delete();
        for (int k = 0; k < 6; k++) step(1'b1);
        check_beats("postrst_l", got_l, 32'hF0F0, 4);
        check_beats("postrst_m", got_m, 32'h0F0F, 4);
        drain();

        // Empty with no valid word
        for (int k = 0; k < 10; k++) step(1'($urandom_range(0, 1)));

        // Randomized traffic and backpressure
        for (int k = 0; k < 400; k++) begin
            if (fifo.size() < 2 && $urandom_range(0, 1) == 1)
                fifo.push_back(16'($urandom));
            step($urandom_range(0, 3) != 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bsg_link_piso_stage
`default_nettype wire
